i2c_config_sequencer: RTL and testbench

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

---
 rtl/i2c_config_sequencer_pkg.sv | 44 ++++
 rtl/i2c_config_sequencer_if.sv | 19 +
 rtl/i2c_config_sequencer_rom.sv | 51 +++++
 rtl/i2c_config_sequencer.sv | 141 ++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_config_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer.
// Holds the sequencer state encoding, the field layout of a 24-bit
// table entry, default parameter values and a helper that packs an entry.
package i2c_config_sequencer_pkg;

   localparam int XFER_W = 24;
   localparam int IDX_W  = 6;

   // xfer_data layout: {slave_addr, reg_addr, data}
   localparam int SLAVE_MSB = 23;
   localparam int SLAVE_LSB = 16;
   localparam int REG_MSB   = 15;
   localparam int REG_LSB   = 8;
   localparam int DATA_MSB  = 7;
   localparam int DATA_LSB  = 0;

   localparam int DEF_TABLE_LEN    = 20;
   localparam int DEF_PWRUP_CYCLES = 1000;
   localparam int DEF_GAP_CYCLES   = 16;
   localparam int DEF_MAX_RETRY    = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PWRUP = 3'd1,
      FETCH = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      GAP   = 3'd5,
      DONE  = 3'd6,
      ERR   = 3'd7
   } state_t;

   function automatic logic [XFER_W-1:0] mk_entry(input logic [7:0] slave,
                                                  input logic [7:0] rg,
                                                  input logic [7:0] dat);
      logic [XFER_W-1:0] e;
      e = '0;
      e[SLAVE_MSB:SLAVE_LSB] = slave;
      e[REG_MSB:REG_LSB]     = rg;
      e[DATA_MSB:DATA_LSB]   = dat;
      return e;
   endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Write-request channel between the configuration sequencer (master) and
// the downstream I2C write engine (slave).
//   xfer_valid/xfer_ready : entry handshake
//   xfer_data             : {slave_addr, reg_addr, data}
//   xfer_done/xfer_nack   : completion pulse and its ACK status
interface i2c_config_sequencer_if;
   import i2c_config_sequencer_pkg::*;

   logic              xfer_valid;
   logic              xfer_ready;
   logic [XFER_W-1:0] xfer_data;
   logic              xfer_done;
   logic              xfer_nack;

   modport master (output xfer_valid, output xfer_data,
                   input  xfer_ready, input  xfer_done, input xfer_nack);
   modport slave  (input  xfer_valid, input  xfer_data,
                   output xfer_ready, output xfer_done, output xfer_nack);
endinterface

// File: rtl/i2c_config_sequencer_rom.sv
// Codec register table (module i2c_config_rom).
// Ports: clk, rst_n (async low), en (read strobe), addr (6-bit entry index),
// data (24-bit entry, registered, valid the cycle after en).
// The output only updates on en so it holds steady while an entry is offered.
module i2c_config_rom
   import i2c_config_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [IDX_W-1:0]  addr,
   output logic [XFER_W-1:0] data
);

   logic [XFER_W-1:0] entry;

   always_comb begin
      entry = '0;
      case (addr)
         // audio codec at 0x34
         6'd0:  entry = mk_entry(8'h34, 8'h1E, 8'h00); // soft reset
         6'd1:  entry = mk_entry(8'h34, 8'h00, 8'h17); // left line in
         6'd2:  entry = mk_entry(8'h34, 8'h02, 8'h17); // right line in
         6'd3:  entry = mk_entry(8'h34, 8'h04, 8'h79); // left headphone
         6'd4:  entry = mk_entry(8'h34, 8'h06, 8'h79); // right headphone
         6'd5:  entry = mk_entry(8'h34, 8'h08, 8'h12); // analog path
         6'd6:  entry = mk_entry(8'h34, 8'h0A, 8'h00); // digital path
         6'd7:  entry = mk_entry(8'h34, 8'h0C, 8'h00); // power down ctrl
         6'd8:  entry = mk_entry(8'h34, 8'h0E, 8'h42); // interface format
         6'd9:  entry = mk_entry(8'h34, 8'h10, 8'h00); // sampling control
         6'd10: entry = mk_entry(8'h34, 8'h12, 8'h01); // activate
         // output amplifier at 0x98
         6'd11: entry = mk_entry(8'h98, 8'h01, 8'h00);
         6'd12: entry = mk_entry(8'h98, 8'h02, 8'h0C);
         6'd13: entry = mk_entry(8'h98, 8'h03, 8'h30);
         6'd14: entry = mk_entry(8'h98, 8'h04, 8'h30);
         6'd15: entry = mk_entry(8'h98, 8'h05, 8'h80);
         6'd16: entry = mk_entry(8'h98, 8'h06, 8'h0F);
         6'd17: entry = mk_entry(8'h98, 8'h07, 8'h00);
         6'd18: entry = mk_entry(8'h98, 8'h08, 8'h44);
         6'd19: entry = mk_entry(8'h98, 8'h00, 8'h01); // amp enable
         default: entry = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  data <= '0;
      else if (en) data <= entry;
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// I2C configuration sequencer: after a start_n falling edge, waits out a
// power-up delay, then writes each table entry through the xfer channel,
// re-issuing NACKed entries up to MAX_RETRY times with a gap between writes.
// Ports: CLK, reset_n (async low), start_n (active-low run request),
// xfer (master side of the write channel), busy, config_done, config_error
// (sticky status), entry_index (current or last entry).
module i2c_config_sequencer
   import i2c_config_sequencer_pkg::*;
#(
   parameter int TABLE_LEN    = DEF_TABLE_LEN,
   parameter int PWRUP_CYCLES = DEF_PWRUP_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int MAX_RETRY    = DEF_MAX_RETRY
)(
   input  logic                   CLK,
   input  logic                   reset_n,
   input  logic                   start_n,
   i2c_config_sequencer_if.master xfer,
   output logic                   busy,
   output logic                   config_done,
   output logic                   config_error,
   output logic [IDX_W-1:0]       entry_index
);

   // one delay counter serves both the power-up wait and the inter-entry gap
   localparam int DLY_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);
   localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [DLY_W-1:0] PWR_LAST = DLY_W'(PWRUP_CYCLES - 1);
   localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(GAP_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_LEN - 1);

   state_t           state, state_nx;
   logic [DLY_W-1:0] dly, dly_nx;
   logic [RTY_W-1:0] retry, retry_nx;
   logic [IDX_W-1:0] idx_nx;
   logic             acked, acked_nx;   // last completed transaction was ACKed
   logic             start_prev;
   logic             start_fall;

   assign start_fall = start_prev & ~start_n;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         dly         <= '0;
         retry       <= '0;
         acked       <= 1'b0;
         entry_index <= '0;
         start_prev  <= 1'b1;
      end else begin
         state       <= state_nx;
         dly         <= dly_nx;
         retry       <= retry_nx;
         acked       <= acked_nx;
         entry_index <= idx_nx;
         start_prev  <= start_n;
      end
   end

   always_comb begin
      state_nx = state;
      dly_nx   = dly;
      retry_nx = retry;
      acked_nx = acked;
      idx_nx   = entry_index;
      case (state)
         IDLE, DONE, ERR: begin
            if (start_fall) begin
               state_nx = PWRUP;
               dly_nx   = '0;
               retry_nx = '0;
               acked_nx = 1'b0;
               idx_nx   = '0;
            end
         end
         PWRUP: begin
            if (dly == PWR_LAST) begin
               state_nx = FETCH;
               dly_nx   = '0;
               idx_nx   = '0;
            end else begin
               dly_nx = dly + 1'b1;
            end
         end
         FETCH: state_nx = ISSUE;
         ISSUE: if (xfer.xfer_ready) state_nx = WAIT;
         WAIT: begin
            if (xfer.xfer_done) begin
               if (!xfer.xfer_nack) begin
                  retry_nx = '0;
                  acked_nx = 1'b1;
                  state_nx = GAP;
               end else if (retry == RTY_MAX) begin
                  state_nx = ERR;
               end else begin
                  retry_nx = retry + 1'b1;
                  acked_nx = 1'b0;
                  state_nx = GAP;
               end
            end
         end
         GAP: begin
            if (dly == GAP_LAST) begin
               dly_nx = '0;
               if (acked && entry_index == IDX_LAST) begin
                  state_nx = DONE;
               end else begin
                  state_nx = FETCH;
                  // a NACKed entry is re-fetched at the same index
                  if (acked) idx_nx = entry_index + 1'b1;
               end
            end else begin
               dly_nx = dly + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign xfer.xfer_valid = (state == ISSUE);
   assign busy            = (state == PWRUP) || (state == FETCH) || (state == ISSUE) ||
                            (state == WAIT)  || (state == GAP);
   assign config_done     = (state == DONE);
   assign config_error    = (state == ERR);

   logic [XFER_W-1:0] rom_data;

   i2c_config_rom u_rom (
      .clk   (CLK),
      .rst_n (reset_n),
      .en    (state == FETCH),
      .addr  (entry_index),
      .data  (rom_data)
   );

   assign xfer.xfer_data = rom_data;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a 3-entry table,
// 10-cycle power-up, 4-cycle gap and 3 retries.
module tb_i2c_config_sequencer;

   localparam logic [23:0] E0 = 24'h341E00;
   localparam logic [23:0] E1 = 24'h340017;
   localparam logic [23:0] E2 = 24'h340217;

   logic       CLK;
   logic       reset_n;
   logic       start_n;
   logic       busy;
   logic       config_done;
   logic       config_error;
   logic [5:0] entry_index;

   int checks = 0;
   int errors = 0;

   i2c_config_sequencer_if xif ();

   i2c_config_sequencer #(
      .TABLE_LEN    (3),
      .PWRUP_CYCLES (10),
      .GAP_CYCLES   (4),
      .MAX_RETRY    (3)
   ) dut (
      .CLK          (CLK),
      .reset_n      (reset_n),
      .start_n      (start_n),
      .xfer         (xif),
      .busy         (busy),
      .config_done  (config_done),
      .config_error (config_error),
      .entry_index  (entry_index)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for an offered entry, accepts it with ready=1, then
   // returns a done pulse with the given nack five cycles later.
   task automatic do_xfer(input string tag, input logic nk,
                          output logic [23:0] d, output logic [5:0] ix, output int wc);
      wc = -1;
      for (int i = 1; i <= 200; i++) begin
         tick;
         if (xif.xfer_valid === 1'b1) begin
            wc = i;
            break;
         end
      end
      d  = xif.xfer_data;
      ix = entry_index;
      if (wc > 0) begin
         tick;
         chk({tag, "_valid_drop"}, {31'd0, xif.xfer_valid}, 32'd0);
         repeat (4) tick;
         xif.xfer_done = 1'b1;
         xif.xfer_nack = nk;
         tick;
         xif.xfer_done = 1'b0;
         xif.xfer_nack = 1'b0;
      end
   endtask

   initial begin : stim
      logic [23:0] d;
      logic [23:0] d0;
      logic [5:0]  ix;
      int          wc;
      int          bad;

      reset_n = 1'b0;
      start_n = 1'b1;
      xif.xfer_ready = 1'b1;
      xif.xfer_done  = 1'b0;
      xif.xfer_nack  = 1'b0;
      repeat (3) tick;
      chk("rst_valid", {31'd0, xif.xfer_valid}, 32'd0);
      chk("rst_data",  {8'd0, xif.xfer_data},  32'd0);
      chk("rst_busy",  {31'd0, busy},          32'd0);
      chk("rst_done",  {31'd0, config_done},   32'd0);
      chk("rst_err",   {31'd0, config_error},  32'd0);
      chk("rst_idx",   {26'd0, entry_index},   32'd0);
      reset_n = 1'b1;
      repeat (2) tick;
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // happy path
      start_n = 1'b0;
      do_xfer("hp0", 1'b0, d, ix, wc);
      chk("hp0_latency", wc, 32'd12);
      chk("hp0_data", {8'd0, d}, {8'd0, E0});
      chk("hp0_idx", {26'd0, ix}, 32'd0);
      do_xfer("hp1", 1'b0, d, ix, wc);
      chk("hp1_gap", wc, 32'd5);
      chk("hp1_data", {8'd0, d}, {8'd0, E1});
      chk("hp1_idx", {26'd0, ix}, 32'd1);
      do_xfer("hp2", 1'b0, d, ix, wc);
      chk("hp2_gap", wc, 32'd5);
      chk("hp2_data", {8'd0, d}, {8'd0, E2});
      chk("hp2_idx", {26'd0, ix}, 32'd2);
      repeat (3) tick;
      chk("hp_done_early", {31'd0, config_done}, 32'd0);
      tick;
      chk("hp_done", {31'd0, config_done}, 32'd1);
      chk("hp_busy", {31'd0, busy}, 32'd0);
      chk("hp_err", {31'd0, config_error}, 32'd0);
      chk("hp_last_idx", {26'd0, entry_index}, 32'd2);
      repeat (20) tick;
      chk("held_low_no_retrigger", {30'd0, config_done, busy}, 32'd2);

      // restart, single NACK on entry 1
      start_n = 1'b1;
      tick;
      start_n = 1'b0;
      tick;
      chk("rs1_done_clr", {31'd0, config_done}, 32'd0);
      chk("rs1_busy", {31'd0, busy}, 32'd1);
      chk("rs1_idx", {26'd0, entry_index}, 32'd0);
      do_xfer("nk0", 1'b0, d, ix, wc);
      chk("nk0_latency", wc, 32'd11);
      chk("nk0_data", {8'd0, d}, {8'd0, E0});
      do_xfer("nk1", 1'b1, d, ix, wc);
      chk("nk1_data", {8'd0, d}, {8'd0, E1});
      do_xfer("nk1r", 1'b0, d, ix, wc);
      chk("nk1r_gap", wc, 32'd5);
      chk("nk1r_data", {8'd0, d}, {8'd0, E1});
      chk("nk1r_idx", {26'd0, ix}, 32'd1);
      do_xfer("nk2", 1'b0, d, ix, wc);
      chk("nk2_data", {8'd0, d}, {8'd0, E2});
      repeat (4) tick;
      chk("nk_done", {30'd0, config_done, config_error}, 32'd2);

      // restart with backpressure on entry 0, then exhaust its retries
      start_n = 1'b1;
      tick;
      start_n = 1'b0;
      xif.xfer_ready = 1'b0;
      wc = -1;
      for (int i = 1; i <= 200; i++) begin
         tick;
         if (xif.xfer_valid === 1'b1) begin
            wc = i;
            break;
         end
      end
      chk("bp_latency", wc, 32'd12);
      d0 = xif.xfer_data;
      chk("bp_data", {8'd0, d0}, {8'd0, E0});
      bad = 0;
      repeat (20) begin
         tick;
         if (xif.xfer_valid !== 1'b1 || xif.xfer_data !== d0 || entry_index !== 6'd0 || busy !== 1'b1)
            bad++;
      end
      chk("bp_stable_cycles_bad", bad, 32'd0);
      xif.xfer_ready = 1'b1;
      tick;
      chk("bp_accept_drop", {31'd0, xif.xfer_valid}, 32'd0);
      repeat (4) tick;
      xif.xfer_done = 1'b1;
      xif.xfer_nack = 1'b1;
      tick;
      xif.xfer_done = 1'b0;
      xif.xfer_nack = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         do_xfer("ex", 1'b1, d, ix, wc);
         chk("ex_gap", wc, 32'd5);
         chk("ex_data", {8'd0, d}, {8'd0, E0});
      end
      chk("ex_err", {31'd0, config_error}, 32'd1);
      chk("ex_done", {31'd0, config_done}, 32'd0);
      chk("ex_busy", {31'd0, busy}, 32'd0);
      chk("ex_idx", {26'd0, entry_index}, 32'd0);
      bad = 0;
      repeat (30) begin
         tick;
         if (xif.xfer_valid !== 1'b0) bad++;
      end
      chk("ex_no_fifth_issue", bad, 32'd0);

      // restart from ERR, reset while entry 1 is in flight
      start_n = 1'b1;
      tick;
      start_n = 1'b0;
      do_xfer("ar0", 1'b0, d, ix, wc);
      chk("ar0_latency", wc, 32'd12);
      chk("ar_err_clr", {31'd0, config_error}, 32'd0);
      wc = -1;
      for (int i = 1; i <= 200; i++) begin
         tick;
         if (xif.xfer_valid === 1'b1) begin
            wc = i;
            break;
         end
      end
      chk("ar1_gap", wc, 32'd5);
      chk("ar1_idx", {26'd0, entry_index}, 32'd1);
      repeat (3) tick;
      chk("ar1_in_wait", {30'd0, busy, xif.xfer_valid}, 32'd2);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_async_busy", {31'd0, busy}, 32'd0);
      chk("ar_async_data", {8'd0, xif.xfer_data}, 32'd0);
      start_n = 1'b1;
      tick;
      reset_n = 1'b1;
      tick;
      xif.xfer_done = 1'b1;
      tick;
      xif.xfer_done = 1'b0;
      bad = 0;
      repeat (30) begin
         tick;
         if (xif.xfer_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("ar_stays_idle", bad, 32'd0);
      chk("ar_data", {8'd0, xif.xfer_data}, 32'd0);
      chk("ar_flags", {30'd0, config_done, config_error}, 32'd0);
      chk("ar_idx", {26'd0, entry_index}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
